// File: rtl/madd_sched_pkg.sv
// Shared types and helpers for the time-shared multiply-add scheduler.
// Holds the operand/result widths, FSM state encoding and the exact reference function.
package madd_sched_pkg;

    localparam int OPW = 6;
    localparam int RW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Exact a*b + c with 2-bit fields; the largest value is 3*3+3 = 12, so it fits in RW bits.
    function automatic logic [RW-1:0] exact_madd(input logic [OPW-1:0] op);
        logic [RW-1:0] a;
        logic [RW-1:0] b;
        logic [RW-1:0] c;
        a = {2'b00, op[1:0]};
        b = {2'b00, op[3:2]};
        c = {2'b00, op[5:4]};
        return (a * b) + c;
    endfunction

endpackage

// File: rtl/madd_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts just after ptr and wraps around, so the most recent winner has the lowest priority.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int cand;

    // The loop walks from the farthest candidate to the nearest one, so the nearest valid requester wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                idx = IW'(cand);
                any = 1'b1;
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/madd_share_sched.sv
// Shares one approximate multiply-add core among N requesters.
// It also tracks how far the core's answers deviate from the exact result.
module madd_share_sched
    import madd_sched_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int CORE_LAT = 1,
    parameter  int ET       = 8,
    parameter  int CW       = 16,
    localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [OPW*N-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IW-1:0]    rsp_id,
    output logic [RW-1:0]    rsp_data,
    output logic [OPW-1:0]   core_in,
    input  logic [RW-1:0]    core_out,
    input  logic             clr_stats,
    output logic [RW-1:0]    err_max,
    output logic [CW-1:0]    viol_cnt,
    output logic             err_flag
);

    localparam int LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    state_t         state_q,    state_d;
    logic [IW-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [IW-1:0]  id_q,       id_d;
    logic [LW-1:0]  lat_cnt_q,  lat_cnt_d;
    logic [OPW-1:0] core_in_q,  core_in_d;
    logic [RW-1:0]  rsp_data_q, rsp_data_d;
    logic [RW-1:0]  err_max_q,  err_max_d;
    logic [CW-1:0]  viol_cnt_q, viol_cnt_d;
    logic           err_flag_q, err_flag_d;

    logic [N-1:0]   arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic           arb_any;
    logic           sample;
    logic [RW-1:0]  exact_v;
    logic [RW-1:0]  err_v;

    rr_arbiter #(.N(N)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        lat_cnt_d  = lat_cnt_q;
        core_in_d  = core_in_q;
        rsp_data_d = rsp_data_q;
        err_max_d  = err_max_q;
        viol_cnt_d = viol_cnt_q;
        err_flag_d = err_flag_q;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        sample     = 1'b0;
        exact_v    = exact_madd(core_in_q);
        err_v      = (exact_v >= core_out) ? (exact_v - core_out) : (core_out - exact_v);

        case (state_q)
            IDLE: begin
                req_ready = arb_gnt;
                if (arb_any) begin
                    core_in_d = req_data[int'(arb_idx)*OPW +: OPW];
                    id_d      = arb_idx;
                    rr_ptr_d  = arb_idx;
                    lat_cnt_d = LW'(CORE_LAT - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    sample     = 1'b1;
                    rsp_data_d = core_out;
                    state_d    = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear in the same cycle as a sample discards that sample.
        if (clr_stats) begin
            err_max_d  = '0;
            viol_cnt_d = '0;
            err_flag_d = 1'b0;
        end else if (sample) begin
            if (err_v > err_max_q) begin
                err_max_d = err_v;
            end
            if (int'(err_v) > ET) begin
                err_flag_d = 1'b1;
                if (viol_cnt_q != '1) begin
                    viol_cnt_d = viol_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IW'(N - 1);
            id_q       <= '0;
            lat_cnt_q  <= '0;
            core_in_q  <= '0;
            rsp_data_q <= '0;
            err_max_q  <= '0;
            viol_cnt_q <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            lat_cnt_q  <= lat_cnt_d;
            core_in_q  <= core_in_d;
            rsp_data_q <= rsp_data_d;
            err_max_q  <= err_max_d;
            viol_cnt_q <= viol_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign rsp_id   = id_q;
    assign rsp_data = rsp_data_q;
    assign core_in  = core_in_q;
    assign err_max  = err_max_q;
    assign viol_cnt = viol_cnt_q;
    assign err_flag = err_flag_q;

endmodule
